// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the fetch PC into a combinational
// instruction memory, buffers fetched words in a prefetch FIFO, handles redirects and faults.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        imem_error,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault,
   output logic [31:0] fault_pc
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic             fault_q, fault_d;
   logic [31:0]      fault_pc_q, fault_pc_d;
   logic             push;
   logic             pop;
   logic             room;

   logic [31:0]      instr_q [FIFO_DEPTH];
   logic [31:0]      pc_q    [FIFO_DEPTH];

   // Next-state: redirect beats everything; a full FIFO with a pop still has room
   always_comb begin
      pop        = (count_q != CNT_ZERO) & out_ready;
      room       = (count_q < DEPTH_C) | pop;
      push       = 1'b0;
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;

      if (redirect_valid) begin
         state_d    = ST_RUN;
         fetch_pc_d = redirect_pc;
         count_d    = CNT_ZERO;
         rd_ptr_d   = PTR_ZERO;
         wr_ptr_d   = PTR_ZERO;
         fault_d    = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (fetch_en & room) begin
                  if (imem_error) begin
                     state_d    = ST_FAULT;
                     fault_d    = 1'b1;
                     fault_pc_d = fetch_pc_q;
                  end else begin
                     push       = 1'b1;
                     fetch_pc_d = fetch_pc_q + 32'd4;
                  end
               end else begin
                  push = 1'b0;
               end
            end
            ST_FAULT: begin
               state_d = ST_FAULT;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase

         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end

         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end

         if (push & ~pop) begin
            count_d = count_q + CNT_ONE;
         end else if (pop & ~push) begin
            count_d = count_q - CNT_ONE;
         end else begin
            count_d = count_q;
         end
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= RESET_PC;
         count_q    <= CNT_ZERO;
         rd_ptr_q   <= PTR_ZERO;
         wr_ptr_q   <= PTR_ZERO;
         fault_q    <= 1'b0;
         fault_pc_q <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   // Prefetch FIFO storage, one {pc, instr} pair per slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            instr_q[i] <= 32'h0000_0000;
            pc_q[i]    <= 32'h0000_0000;
         end
      end else if (push) begin
         instr_q[wr_ptr_q] <= imem_data;
         pc_q[wr_ptr_q]    <= fetch_pc_q;
      end
   end

   assign imem_addr   = fetch_pc_q;
   assign out_valid   = (count_q != CNT_ZERO);
   assign out_instr   = instr_q[rd_ptr_q];
   assign out_pc      = pc_q[rd_ptr_q];
   assign fetch_fault = fault_q;
   assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios then random traffic,
// all compared against a queue-based reference model of the fetch/FIFO rules.
module tb_fetch_sequencer;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        imem_error;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault;
   logic [31:0] fault_pc;

   fetch_sequencer #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fetch_en      (fetch_en),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .imem_error    (imem_error),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .fetch_fault   (fetch_fault),
      .fault_pc      (fault_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: word n holds 0x100+n; faults on misaligned or >= 0x1000
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0000_0100 + (a >> 2);
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
   endfunction

   assign imem_data  = mem_word(imem_addr);
   assign imem_error = mem_err(imem_addr);

   int          total;
   int          bad;
   logic [63:0] m_q[$];
   logic [31:0] m_pc;
   logic        m_fault;
   logic [31:0] m_fault_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_pc       = 32'h0000_0000;
      m_fault    = 1'b0;
      m_fault_pc = 32'h0000_0000;
   endtask

   task automatic check_all();
      chk("out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() != 0)});
      if (m_q.size() != 0) begin
         chk("out_pc", out_pc, m_q[0][63:32]);
         chk("out_instr", out_instr, m_q[0][31:0]);
      end
      chk("imem_addr", imem_addr, m_pc);
      chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
      chk("fault_pc", fault_pc, m_fault_pc);
   endtask

   // One clock of the reference behaviour, using the inputs currently driven
   task automatic model_step();
      logic        pop;
      logic        room;
      logic [63:0] e;
      pop  = (m_q.size() != 0) && out_ready;
      room = (m_q.size() < 4) || pop;
      if (redirect_valid) begin
         m_q.delete();
         m_pc    = redirect_pc;
         m_fault = 1'b0;
      end else begin
         if (pop) e = m_q.pop_front();
         if (!m_fault && fetch_en && room) begin
            if (mem_err(m_pc)) begin
               m_fault    = 1'b1;
               m_fault_pc = m_pc;
            end else begin
               m_q.push_back({m_pc, mem_word(m_pc)});
               m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   task automatic cycle();
      #1;
      check_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic drive(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
      fetch_en       = fe;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      m_reset();
      #12;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
      chk("rst_fault_pc", fault_pc, 32'h0);
      rst_n = 1'b1;
      cycle();

      // sequential fetch
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      cycle();
      chk("seq_first_pc", out_pc, 32'h0);
      chk("seq_first_instr", out_instr, 32'h100);
      run(9);

      // backpressure from a fresh start at 0
      drive(1'b1, 1'b1, 1'b1, 32'h0);
      cycle();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      run(10);
      chk("bp_addr_hold", imem_addr, 32'h10);
      chk("bp_head", out_pc, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      run(2);
      chk("bp_head_after", out_pc, 32'h8);

      // redirect with simultaneous pop, FIFO holds 0x8..0x14
      drive(1'b1, 1'b1, 1'b1, 32'h40);
      cycle();
      chk("rd_flush", {31'd0, out_valid}, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      cycle();
      chk("rd_first", out_pc, 32'h40);
      cycle();
      chk("rd_second", out_pc, 32'h44);

      // unaligned redirect target faults
      drive(1'b1, 1'b1, 1'b1, 32'h1002);
      cycle();
      chk("flt_addr", imem_addr, 32'h1002);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      cycle();
      chk("flt_set", {31'd0, fetch_fault}, 32'd1);
      chk("flt_pc", fault_pc, 32'h1002);
      run(3);
      chk("flt_hold", imem_addr, 32'h1002);
      chk("flt_novalid", {31'd0, out_valid}, 32'd0);
      drive(1'b1, 1'b1, 1'b1, 32'h0);
      cycle();
      chk("flt_clear", {31'd0, fetch_fault}, 32'd0);
      chk("flt_keep_pc", fault_pc, 32'h1002);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      cycle();
      chk("flt_resume", out_pc, 32'h0);

      // out-of-range walk from 0xFF8
      drive(1'b1, 1'b0, 1'b1, 32'hFF8);
      cycle();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      run(3);
      chk("oor_fault", {31'd0, fetch_fault}, 32'd1);
      chk("oor_fault_pc", fault_pc, 32'h1000);
      chk("oor_head", out_pc, 32'hFF8);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      cycle();
      chk("oor_drain", out_pc, 32'hFFC);
      cycle();
      chk("oor_empty", {31'd0, out_valid}, 32'd0);

      // async reset with three entries buffered and a fault pending
      drive(1'b1, 1'b0, 1'b1, 32'hFF4);
      cycle();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      run(4);
      chk("ar_pre_fault", {31'd0, fetch_fault}, 32'd1);
      chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", {31'd0, out_valid}, 32'd0);
      chk("ar_fault", {31'd0, fetch_fault}, 32'd0);
      chk("ar_addr", imem_addr, 32'h0);
      m_reset();
      #2;
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      cycle();

      // random traffic around the memory boundary
      for (int i = 0; i < 400; i++) begin
         logic [31:0] rpc;
         if ($urandom_range(7, 0) == 0)
            rpc = $urandom_range(32'h1010, 32'h0);
         else
            rpc = $urandom_range(32'h1010, 32'h0F00) & ~32'd3;
         drive(($urandom_range(7, 0) != 0), $urandom_range(1, 0) == 1,
               ($urandom_range(15, 0) == 0), rpc);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
